// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-memory stage: FSM state encoding,
// byte-enable constants and architectural register indices.
package cpu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_t;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] PC_REG   = 4'd15;

endpackage

// File: rtl/load_store_unit_if.sv
// Data RAM bus between the load/store unit (master) and the synchronous RAM (slave).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the data RAM: store byte enables/replication and
// load extraction (byte zero-extend, ARM7 rotate for unaligned words).
module lsu_align
    import cpu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        byteOrWord,
    input  logic [31:0] storeData,
    input  logic [31:0] memRdata,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    output logic [31:0] loadData
);

    logic [4:0]  shAmt;
    logic [63:0] rotated;

    always_comb begin
        shAmt   = {lane, 3'b000};
        rotated = {memRdata, memRdata} >> shAmt;
        if (byteOrWord) begin
            memBe    = BE_BYTE0 << lane;
            memWdata = {4{storeData[7:0]}};
            loadData = {24'd0, memRdata[shAmt +: 8]};
        end else begin
            memBe    = BE_WORD;
            memWdata = storeData;
            loadData = rotated[31:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: latches an LDR/STR request, drives the synchronous RAM
// and emits one-cycle register-file writeback requests with done.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 cond_pass,
    input  logic                 load_store,
    input  logic                 byte_or_word,
    input  logic                 pre_post,
    input  logic                 up_down,
    input  logic                 write_back,
    input  logic [31:0]          base_val,
    input  logic [31:0]          offset,
    input  logic [DATA_W-1:0]    store_data,
    input  logic [3:0]           rd,
    input  logic [3:0]           rn,
    load_store_unit_if.master    mem,
    output logic                 busy,
    output logic                 done,
    output logic                 wb_data_en,
    output logic [3:0]           wb_data_reg,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_base_en,
    output logic [3:0]           wb_base_reg,
    output logic [31:0]          wb_base_val
);

    lsu_state_t state;

    logic        loadLat, byteLat, baseEnLat;
    logic [1:0]  laneLat;
    logic [3:0]  rdLat, rnLat;
    logic [31:0] eaLat;

    logic [31:0] ea, acc;
    logic        baseEnNext;
    logic [1:0]  laneSel;
    logic        byteSel;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata, alignLoad;

    always_comb begin
        ea         = up_down ? base_val + offset : base_val - offset;
        acc        = pre_post ? ea : base_val;
        baseEnNext = (!pre_post | write_back) & !(load_store & (rd == rn));
        // Store lanes come straight from the request; load lanes from the latch.
        laneSel    = (state == LSU_IDLE) ? acc[1:0] : laneLat;
        byteSel    = (state == LSU_IDLE) ? byte_or_word : byteLat;
    end

    lsu_align u_align (
        .lane       (laneSel),
        .byteOrWord (byteSel),
        .storeData  (store_data),
        .memRdata   (mem.mem_rdata),
        .memBe      (alignBe),
        .memWdata   (alignWdata),
        .loadData   (alignLoad)
    );

    always_ff @(posedge clk) begin
        if (nreset) begin
            state         <= LSU_IDLE;
            loadLat       <= 1'b0;
            byteLat       <= 1'b0;
            baseEnLat     <= 1'b0;
            laneLat       <= '0;
            rdLat         <= '0;
            rnLat         <= '0;
            eaLat         <= '0;
            mem.mem_en    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wb_data_en    <= 1'b0;
            wb_data_reg   <= '0;
            wb_data       <= '0;
            wb_base_en    <= 1'b0;
            wb_base_reg   <= '0;
            wb_base_val   <= '0;
        end else begin
            done          <= 1'b0;
            wb_data_en    <= 1'b0;
            wb_data_reg   <= '0;
            wb_data       <= '0;
            wb_base_en    <= 1'b0;
            wb_base_reg   <= '0;
            wb_base_val   <= '0;
            mem.mem_en    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            case (state)
                LSU_IDLE: begin
                    if (start) begin
                        loadLat   <= load_store;
                        byteLat   <= byte_or_word;
                        baseEnLat <= baseEnNext;
                        laneLat   <= acc[1:0];
                        rdLat     <= rd;
                        rnLat     <= rn;
                        eaLat     <= ea;
                        busy      <= 1'b1;
                        if (cond_pass) begin
                            state         <= LSU_ACCESS;
                            mem.mem_en    <= 1'b1;
                            mem.mem_we    <= !load_store;
                            mem.mem_addr  <= {acc[ADDR_W-1:2], 2'b00};
                            mem.mem_be    <= load_store ? 4'b0000 : alignBe;
                            mem.mem_wdata <= load_store ? '0 : alignWdata;
                        end else begin
                            state <= LSU_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (loadLat) begin
                        state <= LSU_WAIT;
                    end else begin
                        state       <= LSU_DONE;
                        done        <= 1'b1;
                        wb_data_reg <= rdLat;
                        wb_base_en  <= baseEnLat;
                        wb_base_reg <= rnLat;
                        wb_base_val <= eaLat;
                    end
                end
                LSU_WAIT: begin
                    state       <= LSU_DONE;
                    done        <= 1'b1;
                    wb_data_en  <= 1'b1;
                    wb_data_reg <= rdLat;
                    wb_data     <= alignLoad;
                    wb_base_en  <= baseEnLat;
                    wb_base_reg <= rnLat;
                    wb_base_val <= eaLat;
                end
                default: begin
                    state <= LSU_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
